// File: rtl/deser_align_ctrl.sv
// Word-alignment controller for a 40-bit deserializer.
// Sweeps the deserializer delay tap until a masked frame marker is seen
// LOCK_COUNT times in a row, then monitors marker presence per window and
// drops lock after UNLOCK_COUNT consecutive marker-less windows.
module deser_align_ctrl #(
    parameter logic [39:0] MARKER_PATTERN = 40'h3C5C000000,
    parameter logic [39:0] MARKER_MASK    = 40'hFFFF000000,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned LOCK_COUNT     = 16,
    parameter int unsigned WINDOW         = 64,
    parameter int unsigned UNLOCK_COUNT   = 4
) (
    input  logic        i_word40CK,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [4:0]  i_manualDelay,
    input  logic        i_wordValid,
    input  logic [39:0] i_frameWord,
    output logic [4:0]  o_delay,
    output logic        o_aligned,
    output logic [2:0]  o_state,
    output logic        o_sweepFail,
    output logic [7:0]  o_lockLossCnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_CONFIRM = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [9:0] WIN_LAST    = 10'(WINDOW - 1);
    localparam logic [7:0] LOCK_TGT    = 8'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_TGT  = 4'(UNLOCK_COUNT);

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_delay, w_delay_nxt;
    logic [7:0]  r_settle_cnt, w_settle_nxt;
    logic [9:0]  r_win_cnt, w_win_nxt;
    logic [7:0]  r_conf_cnt, w_conf_nxt;
    logic [3:0]  r_miss_cnt, w_miss_nxt;
    logic        r_win_hit, w_hit_nxt;
    logic [5:0]  r_steps, w_steps_nxt;
    logic        r_sweep_fail, w_sweep_nxt;
    logic [7:0]  r_loss_cnt, w_loss_nxt;

    logic        w_marker;
    logic        w_step;
    logic        w_win_marked;
    logic [7:0]  w_conf_inc;
    logic [3:0]  w_miss_inc;
    logic [5:0]  w_steps_inc;

    // Masked marker compare; invalid words never count as markers.
    assign w_marker = i_wordValid &&
                      ((i_frameWord & MARKER_MASK) == (MARKER_PATTERN & MARKER_MASK));

    assign w_conf_inc   = r_conf_cnt + 8'd1;
    assign w_miss_inc   = r_miss_cnt + 4'd1;
    assign w_steps_inc  = r_steps + 6'd1;
    assign w_win_marked = r_win_hit | w_marker;

    // State register.
    always_ff @(posedge i_word40CK) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state and datapath next values; every counter update happens here.
    always_comb begin
        w_state_nxt  = r_state;
        w_delay_nxt  = r_delay;
        w_settle_nxt = r_settle_cnt;
        w_win_nxt    = r_win_cnt;
        w_conf_nxt   = r_conf_cnt;
        w_miss_nxt   = r_miss_cnt;
        w_hit_nxt    = r_win_hit;
        w_steps_nxt  = r_steps;
        w_sweep_nxt  = r_sweep_fail;
        w_loss_nxt   = r_loss_cnt;
        w_step       = 1'b0;

        if (!i_enable) begin
            // Manual mode: delay follows the manual input, search state discarded.
            w_state_nxt = ST_IDLE;
            w_delay_nxt = i_manualDelay;
            w_steps_nxt = 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Sweep starts from whatever delay is currently applied.
                    w_state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (i_wordValid) begin
                        if (r_settle_cnt == SETTLE_LAST) w_state_nxt  = ST_SEARCH;
                        else                             w_settle_nxt = r_settle_cnt + 8'd1;
                    end
                end
                ST_SEARCH: begin
                    if (w_marker) begin
                        if (LOCK_TGT == 8'd1) begin
                            w_state_nxt = ST_LOCKED;
                        end else begin
                            w_state_nxt = ST_CONFIRM;
                            w_conf_nxt  = 8'd1;
                        end
                    end else if (i_wordValid) begin
                        if (r_win_cnt == WIN_LAST) w_step    = 1'b1;
                        else                       w_win_nxt = r_win_cnt + 10'd1;
                    end
                end
                ST_CONFIRM: begin
                    if (w_marker) begin
                        if (w_conf_inc == LOCK_TGT) w_state_nxt = ST_LOCKED;
                        else                        w_conf_nxt  = w_conf_inc;
                    end else if (i_wordValid) begin
                        w_step = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (i_wordValid) begin
                        if (r_win_cnt == WIN_LAST) begin
                            w_win_nxt = 10'd0;
                            w_hit_nxt = 1'b0;
                            if (w_win_marked) begin
                                w_miss_nxt = 4'd0;
                            end else if (w_miss_inc == UNLOCK_TGT) begin
                                w_step = 1'b1;
                                if (r_loss_cnt != 8'hFF) w_loss_nxt = r_loss_cnt + 8'd1;
                            end else begin
                                w_miss_nxt = w_miss_inc;
                            end
                        end else begin
                            w_win_nxt = r_win_cnt + 10'd1;
                            w_hit_nxt = w_win_marked;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        // Delay step: move one tap, flag a completed 32-tap sweep, resettle.
        if (w_step) begin
            w_state_nxt = ST_SETTLE;
            w_delay_nxt = r_delay + 5'd1;
            if (w_steps_inc == 6'd32) begin
                w_steps_nxt = 6'd0;
                w_sweep_nxt = 1'b1;
            end else begin
                w_steps_nxt = w_steps_inc;
            end
        end

        // Per-state counters restart on any transition; CONFIRM keeps its seed of 1.
        if (w_state_nxt != r_state) begin
            w_settle_nxt = 8'd0;
            w_win_nxt    = 10'd0;
            w_miss_nxt   = 4'd0;
            w_hit_nxt    = 1'b0;
            if (w_state_nxt != ST_CONFIRM) w_conf_nxt = 8'd0;
            if (w_state_nxt == ST_LOCKED)  w_steps_nxt = 6'd0;
        end
    end

    // Datapath registers; reset overrides every input.
    always_ff @(posedge i_word40CK) begin
        if (i_reset) begin
            r_delay      <= 5'd0;
            r_settle_cnt <= 8'd0;
            r_win_cnt    <= 10'd0;
            r_conf_cnt   <= 8'd0;
            r_miss_cnt   <= 4'd0;
            r_win_hit    <= 1'b0;
            r_steps      <= 6'd0;
            r_sweep_fail <= 1'b0;
            r_loss_cnt   <= 8'd0;
        end else begin
            r_delay      <= w_delay_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_win_cnt    <= w_win_nxt;
            r_conf_cnt   <= w_conf_nxt;
            r_miss_cnt   <= w_miss_nxt;
            r_win_hit    <= w_hit_nxt;
            r_steps      <= w_steps_nxt;
            r_sweep_fail <= w_sweep_nxt;
            r_loss_cnt   <= w_loss_nxt;
        end
    end

    assign o_delay       = r_delay;
    assign o_state       = r_state;
    assign o_aligned     = (r_state == ST_LOCKED);
    assign o_sweepFail   = r_sweep_fail;
    assign o_lockLossCnt = r_loss_cnt;

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Directed bench for deser_align_ctrl with default parameters.
// A small channel model returns marker words only at a chosen delay tap.
module tb_deser_align_ctrl;

    localparam logic [39:0] MARK = 40'h3C5CAA5500;
    localparam logic [39:0] DATA = 40'h0123456789;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [4:0]  manualDelay;
    logic        wordValid;
    logic [39:0] frameWord;
    logic [4:0]  delay;
    logic        aligned;
    logic [2:0]  state;
    logic        sweepFail;
    logic [7:0]  lockLossCnt;

    int checks = 0;
    int errors = 0;

    deser_align_ctrl dut (
        .i_word40CK   (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_manualDelay(manualDelay),
        .i_wordValid  (wordValid),
        .i_frameWord  (frameWord),
        .o_delay      (delay),
        .o_aligned    (aligned),
        .o_state      (state),
        .o_sweepFail  (sweepFail),
        .o_lockLossCnt(lockLossCnt)
    );

    always #5 clk = ~clk;

    // One clock: inputs applied, sampled at the edge, outputs settle 1 time unit later.
    task automatic step(input logic v, input logic [39:0] w);
        wordValid = v;
        frameWord = w;
        @(posedge clk);
        #1;
    endtask

    // Channel: n valid words, markers only while the applied delay equals good.
    task automatic chan(input int n, input int good);
        for (int i = 0; i < n; i++)
            step(1'b1, (good >= 0 && int'(delay) == good) ? MARK : DATA);
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; manualDelay = 5'd9;
        step(1'b1, MARK);
        step(1'b1, MARK);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (delay !== 5'd0) begin errors++; $display("FAIL reset_delay: got %0d want 0", delay); end
        checks++; if ({aligned, sweepFail, lockLossCnt} !== 10'd0) begin errors++;
            $display("FAIL reset_flags: got al=%0b sf=%0b llc=%0d want 0/0/0", aligned, sweepFail, lockLossCnt); end
        enable = 1'b0;
        reset  = 1'b0;
        step(1'b0, DATA);
    endtask

    task automatic test_manual;
        enable = 1'b0; manualDelay = 5'd13;
        step(1'b0, DATA);
        checks++; if (delay !== 5'd13) begin errors++; $display("FAIL manual_delay: got %0d want 13", delay); end
        checks++; if (state !== 3'd0 || aligned !== 1'b0) begin errors++;
            $display("FAIL manual_state: got st=%0d al=%0b want 0/0", state, aligned); end
        manualDelay = 5'd0;
        step(1'b1, MARK);
        checks++; if (delay !== 5'd0 || state !== 3'd0) begin errors++;
            $display("FAIL manual_zero: got d=%0d st=%0d want 0/0", delay, state); end
    endtask

    // Markers only at tap 5; sweep from 0 steps every 8+64 valid words.
    task automatic test_search_lock;
        enable = 1'b1;
        step(1'b0, DATA);
        checks++; if (state !== 3'd1 || delay !== 5'd0) begin errors++;
            $display("FAIL start_settle: got st=%0d d=%0d want 1/0", state, delay); end
        for (int k = 0; k < 5; k++) begin
            chan(71, 5);
            checks++; if (state !== 3'd2 || delay !== 5'(k)) begin errors++;
                $display("FAIL sweep_hold_%0d: got st=%0d d=%0d want 2/%0d", k, state, delay, k); end
            chan(1, 5);
            checks++; if (state !== 3'd1 || delay !== 5'(k + 1)) begin errors++;
                $display("FAIL sweep_step_%0d: got st=%0d d=%0d want 1/%0d", k, state, delay, k + 1); end
        end
        chan(8, 5);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL settle_done: got %0d want 2", state); end
        chan(1, 5);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL confirm_enter: got %0d want 3", state); end
        chan(14, 5);
        checks++; if (state !== 3'd3 || aligned !== 1'b0) begin errors++;
            $display("FAIL confirm_15: got st=%0d al=%0b want 3/0", state, aligned); end
        chan(1, 5);
        checks++; if (state !== 3'd4 || aligned !== 1'b1 || delay !== 5'd5) begin errors++;
            $display("FAIL lock_at_5: got st=%0d al=%0b d=%0d want 4/1/5", state, aligned, delay); end
    endtask

    // Three empty windows then a marked one keeps lock; four empty windows drop it.
    task automatic test_lock_loss;
        chan(100, -1);
        step(1'b0, MARK);
        step(1'b0, MARK);
        chan(92, -1);
        chan(1, 5);
        chan(63, -1);
        checks++; if (state !== 3'd4 || aligned !== 1'b1) begin errors++;
            $display("FAIL keep_lock: got st=%0d al=%0b want 4/1", state, aligned); end
        chan(255, -1);
        checks++; if (state !== 3'd4 || delay !== 5'd5) begin errors++;
            $display("FAIL before_loss: got st=%0d d=%0d want 4/5", state, delay); end
        chan(1, -1);
        checks++; if (aligned !== 1'b0 || delay !== 5'd6 || state !== 3'd1) begin errors++;
            $display("FAIL loss: got al=%0b d=%0d st=%0d want 0/6/1", aligned, delay, state); end
        checks++; if (lockLossCnt !== 8'd1) begin errors++; $display("FAIL loss_cnt: got %0d want 1", lockLossCnt); end
    endtask

    // Non-marker in CONFIRM steps; invalid gaps leave the confirm count alone.
    task automatic test_confirm_gaps;
        chan(8, 6);
        chan(10, 6);
        for (int i = 0; i < 3; i++) step(1'b0, DATA);
        checks++; if (state !== 3'd3 || delay !== 5'd6) begin errors++;
            $display("FAIL gap_hold: got st=%0d d=%0d want 3/6", state, delay); end
        step(1'b1, DATA);
        checks++; if (state !== 3'd1 || delay !== 5'd7) begin errors++;
            $display("FAIL confirm_break: got st=%0d d=%0d want 1/7", state, delay); end
        chan(8, 7);
        chan(10, 7);
        for (int i = 0; i < 4; i++) step(1'b0, MARK);
        chan(5, 7);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL gap_count: got %0d want 3", state); end
        chan(1, 7);
        checks++; if (state !== 3'd4 || lockLossCnt !== 8'd1) begin errors++;
            $display("FAIL gap_lock: got st=%0d llc=%0d want 4/1", state, lockLossCnt); end
    endtask

    // No markers anywhere: from tap 30, wrap 31->0, flag after the 32nd step.
    task automatic test_sweep_fail;
        enable = 1'b0; manualDelay = 5'd30;
        step(1'b0, DATA);
        checks++; if (state !== 3'd0 || delay !== 5'd30 || sweepFail !== 1'b0) begin errors++;
            $display("FAIL sweep_idle: got st=%0d d=%0d sf=%0b want 0/30/0", state, delay, sweepFail); end
        enable = 1'b1;
        step(1'b0, DATA);
        chan(72, -1);
        checks++; if (delay !== 5'd31) begin errors++; $display("FAIL sweep_31: got %0d want 31", delay); end
        chan(72, -1);
        checks++; if (delay !== 5'd0) begin errors++; $display("FAIL sweep_wrap: got %0d want 0", delay); end
        for (int i = 0; i < 29; i++) chan(72, -1);
        checks++; if (sweepFail !== 1'b0 || delay !== 5'd29) begin errors++;
            $display("FAIL sweep_31_steps: got sf=%0b d=%0d want 0/29", sweepFail, delay); end
        chan(72, -1);
        checks++; if (sweepFail !== 1'b1 || delay !== 5'd30 || state !== 3'd1) begin errors++;
            $display("FAIL sweep_flag: got sf=%0b d=%0d st=%0d want 1/30/1", sweepFail, delay, state); end
        chan(72, -1);
        checks++; if (sweepFail !== 1'b1 || delay !== 5'd31 || state !== 3'd1) begin errors++;
            $display("FAIL sweep_continue: got sf=%0b d=%0d st=%0d want 1/31/1", sweepFail, delay, state); end
    endtask

    // Raise lockLossCnt to 3, lock again, then reset while LOCKED.
    task automatic test_reset_locked;
        enable = 1'b0; manualDelay = 5'd5;
        step(1'b0, DATA);
        enable = 1'b1;
        step(1'b0, DATA);
        chan(24, 5);
        chan(256, -1);
        checks++; if (lockLossCnt !== 8'd2 || delay !== 5'd6) begin errors++;
            $display("FAIL loss_2: got llc=%0d d=%0d want 2/6", lockLossCnt, delay); end
        chan(24, 6);
        chan(256, -1);
        chan(24, 7);
        checks++; if (state !== 3'd4 || lockLossCnt !== 8'd3 || delay !== 5'd7) begin errors++;
            $display("FAIL relock: got st=%0d llc=%0d d=%0d want 4/3/7", state, lockLossCnt, delay); end
        reset = 1'b1;
        step(1'b1, MARK);
        checks++; if (state !== 3'd0 || delay !== 5'd0 || aligned !== 1'b0) begin errors++;
            $display("FAIL rst_lock_state: got st=%0d d=%0d al=%0b want 0/0/0", state, delay, aligned); end
        checks++; if (lockLossCnt !== 8'd0 || sweepFail !== 1'b0) begin errors++;
            $display("FAIL rst_lock_stats: got llc=%0d sf=%0b want 0/0", lockLossCnt, sweepFail); end
        reset = 1'b0;
        step(1'b1, MARK);
        checks++; if (state !== 3'd1 || delay !== 5'd0) begin errors++;
            $display("FAIL rst_restart: got st=%0d d=%0d want 1/0", state, delay); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; manualDelay = 5'd0;
        wordValid = 1'b0; frameWord = DATA;
        #2;
        test_reset;
        test_manual;
        test_search_lock;
        test_lock_loss;
        test_confirm_gaps;
        test_sweep_fail;
        test_reset_locked;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/deser_align_ctrl.md
DESER_ALIGN_CTRL -- requirements
Module: deser_align_ctrl

Interface
REQ-001 Parameter MARKER_PATTERN, default 40'h3C5C000000, frame-marker value compared under mask.
REQ-002 Parameter MARKER_MASK, default 40'hFFFF000000, bits participating in the marker compare.
REQ-003 Parameter SETTLE_CYCLES, default 8, words ignored after every delay change (1..255).
REQ-004 Parameter LOCK_COUNT, default 16, consecutive markers required to declare lock (1..255).
REQ-005 Parameter WINDOW, default 64, valid-word window length for search timeout and lock monitoring (1..1023).
REQ-006 Parameter UNLOCK_COUNT, default 4, consecutive marker-less windows that drop lock (1..15).
REQ-007 word40CK  input  1  word clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 enable  input  1  1 = automatic alignment; 0 = manual delay.
REQ-010 manualDelay  input  5  delay value used while enable=0.
REQ-011 wordValid  input  1  frameWord is valid this cycle.
REQ-012 frameWord  input  40  deserialized 40-bit word.
REQ-013 delay  output  5  registered delay driven to the deserializer.
REQ-014 aligned  output  1  high only in LOCKED.
REQ-015 state  output  3  IDLE=0, SETTLE=1, SEARCH=2, CONFIRM=3, LOCKED=4.
REQ-016 sweepFail  output  1  sticky: a full 32-delay sweep completed without lock.
REQ-017 lockLossCnt  output  8  saturating count of LOCKED exits due to marker loss.

Function
REQ-018 A word is a marker when wordValid=1 and (frameWord & MARKER_MASK) == (MARKER_PATTERN & MARKER_MASK); words with wordValid=0 are ignored by every counter.
REQ-019 IDLE: delay <= manualDelay each cycle; enable=1 -> SETTLE, starting at the current delay value.
REQ-020 enable=0 in any state -> IDLE next cycle, aligned=0, counters cleared, sweepFail and lockLossCnt held.
REQ-021 SETTLE: count SETTLE_CYCLES valid words, then -> SEARCH; no compare is done in SETTLE.
REQ-022 SEARCH: marker -> CONFIRM with confirm count=1; WINDOW valid words without a marker -> step delay.
REQ-023 CONFIRM: each marker increments the confirm count; reaching LOCK_COUNT -> LOCKED; any non-marker valid word -> step delay.
REQ-024 With LOCK_COUNT=1, the first SEARCH marker goes directly to LOCKED.
REQ-025 Step delay: delay <= delay+1 modulo 32 (31 wraps to 0), the steps counter increments, -> SETTLE; delay changes on the same edge as the state change.
REQ-026 After 32 delay steps since the last entry from IDLE or last lock, sweepFail <= 1 and the steps counter clears; sweeping continues.
REQ-027 LOCKED: aligned=1, delay frozen; each WINDOW valid words form a window; a window with >=1 marker clears the miss counter, a window without one increments it.
REQ-028 Miss counter reaching UNLOCK_COUNT -> step delay (REQ-025), lockLossCnt increments (saturates at 255), aligned=0 on the same edge.
REQ-029 sweepFail clears only on reset; entering LOCKED clears the steps counter.
REQ-030 Window and confirm counters clear on every state change.

Reset
REQ-031 reset=1 -> state=IDLE, delay=0, aligned=0, sweepFail=0, lockLossCnt=0, all internal counters 0; reset overrides enable and all other inputs.
REQ-032 Reset asserted mid-search or while LOCKED takes effect on the next edge with no partial update.

Verification
REQ-033 enable=0, manualDelay=13 -> delay=13 one cycle later, state=IDLE, aligned=0.
REQ-034 Marker stream valid only at delay 5, auto start at 0 -> delay steps 0..5 every SETTLE+WINDOW valid words; LOCKED after 16 markers at delay 5, aligned=1.
REQ-035 Locked at 5, then marker-free data for 4x64 valid words -> aligned=0, delay=6, lockLossCnt=1; 3 marker-free windows then one marker -> stays LOCKED.
REQ-036 No markers at any delay, start at 30 -> delay wraps 31->0; sweepFail=1 after the 32nd step; sweeping continues.
REQ-037 CONFIRM at count 10 with one non-marker word -> delay+1, state=SETTLE; wordValid=0 gaps leave all counts unchanged.
REQ-038 reset pulse while LOCKED with lockLossCnt=3 -> next cycle state=0, delay=0, lockLossCnt=0, sweepFail=0.
